div_unit: RTL and testbench



---
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit.sv | 99 +++++++++
 tb/tb_div_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Request/response bundle between the EXE stage and the divide unit.
// master drives operands and control; slave returns status and results.
interface div_unit_if;
    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    modport master (
        output div_start, div_signed, dividend, divisor, cancel,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  div_start, div_signed, dividend, divisor, cancel,
        output busy, done, quotient, remainder
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// 32 iterations on magnitudes, sign fix-up applied when entering DONE.
module div_unit (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic [4:0]  count;
    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [31:0] dvs_r;
    logic        neg_q;
    logic        neg_r;
    logic        dz;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic        ge;
    logic [31:0] quo_nxt;
    logic [31:0] rem_nxt;
    logic [31:0] q_fin;
    logic [31:0] r_fin;

    assign accept = (state != CALC) & bus.div_start & ~bus.cancel;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        unique case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: begin
                if (bus.cancel)        state_nxt = IDLE;
                else if (count == 5'd31) state_nxt = DONE;
            end
            DONE: state_nxt = accept ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!rst) begin
            bus.busy = accept | (state == CALC);
            bus.done = (state == DONE);
        end
    end

    assign a_mag = (bus.div_signed & bus.dividend[31]) ? -bus.dividend : bus.dividend;
    assign b_mag = (bus.div_signed & bus.divisor[31])  ? -bus.divisor  : bus.divisor;

    // Partial remainder stays below the divisor, so a negative trial
    // always lands with bit 32 set and a positive one always below 2^32.
    assign shifted = {rem_r, quo_r[31]};
    assign trial   = shifted - {1'b0, dvs_r};
    assign ge      = ~trial[32];
    assign rem_nxt = ge ? trial[31:0] : shifted[31:0];
    assign quo_nxt = {quo_r[30:0], ge};

    assign q_fin = dz    ? 32'hFFFF_FFFF : (neg_q ? -quo_nxt : quo_nxt);
    assign r_fin = neg_r ? -rem_nxt : rem_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            count         <= '0;
            quo_r         <= '0;
            rem_r         <= '0;
            dvs_r         <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            dz            <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
        end else if (accept) begin
            count <= '0;
            quo_r <= a_mag;
            rem_r <= '0;
            dvs_r <= b_mag;
            neg_q <= bus.div_signed & (bus.dividend[31] ^ bus.divisor[31]);
            neg_r <= bus.div_signed & bus.dividend[31];
            dz    <= (bus.divisor == 32'd0);
        end else if (state == CALC && !bus.cancel) begin
            count <= count + 5'd1;
            quo_r <= quo_nxt;
            rem_r <= rem_nxt;
            if (count == 5'd31) begin
                bus.quotient  <= q_fin;
                bus.remainder <= r_fin;
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: random and directed divides
// against an arithmetic reference model.
module tb_div_unit;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   busy_err = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;
    exp_t sb_q[$];

    div_unit_if dif();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b, logic s);
        int sa;
        int sb;
        int q;
        int r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (!s) return {a / b, a % b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'd0};
        sa = $signed(a);
        sb = $signed(b);
        q = sa / sb;
        r = sa % sb;
        return {q, r};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && dif.done) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d want no pulse", cyc);
            end else begin
                e = sb_q.pop_front();
                check("quotient", dif.quotient, e.q);
                check("remainder", dif.remainder, e.r);
                check("done_cycle", cyc, e.cyc);
                last_q = e.q;
                last_r = e.r;
            end
        end
    end

    // Called just after a rising edge; start is held for one cycle (cycle 0).
    task automatic issue(logic [31:0] a, logic [31:0] b, logic s, bit push);
        exp_t e;
        logic [63:0] m;
        dif.div_start  = 1'b1;
        dif.div_signed = s;
        dif.dividend   = a;
        dif.divisor    = b;
        if (push) begin
            m = ref_div(a, b, s);
            e.q = m[63:32];
            e.r = m[31:0];
            e.cyc = cyc + 33;
            sb_q.push_back(e);
        end
        @(negedge clk);
        if (dif.busy !== 1'b1) busy_err++;
        @(posedge clk);
        #1;
        dif.div_start = 1'b0;
        dif.dividend  = $urandom;
        dif.divisor   = $urandom;
    endtask

    task automatic finish_run();
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (dif.busy !== 1'b1) busy_err++;
        end
        @(negedge clk);
        if (dif.busy !== 1'b0) busy_err++;
        check("busy_window", busy_err, 0);
        busy_err = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic run(logic [31:0] a, logic [31:0] b, logic s);
        busy_err = 0;
        issue(a, b, s, 1'b1);
        finish_run();
    endtask

    task automatic b2b(logic [31:0] a0, logic [31:0] b0, logic s0,
                       logic [31:0] a1, logic [31:0] b1, logic s1);
        busy_err = 0;
        issue(a0, b0, s0, 1'b1);
        repeat (32) @(posedge clk);
        #1;
        issue(a1, b1, s1, 1'b1);
        finish_run();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish want finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int done_seen;
        logic [31:0] a;
        logic [31:0] b;
        logic s;
        dif.div_start  = 1'b1;
        dif.div_signed = 1'b0;
        dif.dividend   = 32'd5;
        dif.divisor    = 32'd3;
        dif.cancel     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, dif.busy}, 0);
        check("rst_done", {31'd0, dif.done}, 0);
        check("rst_quotient", dif.quotient, 0);
        check("rst_remainder", dif.remainder, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dif.div_start = 1'b0;
        @(posedge clk);
        #1;

        run(32'd100, 32'd7, 1'b0);
        run(32'hFFFF_FF9C, 32'd7, 1'b1);
        run(32'd100, 32'hFFFF_FFF9, 1'b1);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run(32'h1234_5678, 32'd0, 1'b0);
        run(32'hFFFF_FF9C, 32'd0, 1'b1);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        b2b(32'd1000, 32'd33, 1'b0, 32'hFFFF_FC18, 32'd33, 1'b1);

        // cancel in CALC cycle 10
        busy_err = 0;
        issue(32'd999, 32'd10, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        dif.cancel = 1'b1;
        @(posedge clk);
        #1;
        dif.cancel = 1'b0;
        @(negedge clk);
        check("cancel_busy", {31'd0, dif.busy}, 0);
        check("cancel_quotient", dif.quotient, last_q);
        check("cancel_remainder", dif.remainder, last_r);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (dif.done) done_seen++;
        end
        check("cancel_no_done", done_seen, 0);
        @(posedge clk);
        #1;
        run(32'd999, 32'd10, 1'b0);

        // reset in CALC cycle 5 with start held
        issue(32'd77, 32'd3, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        dif.div_start = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rstmid_busy", {31'd0, dif.busy}, 0);
            check("rstmid_done", {31'd0, dif.done}, 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        dif.div_start = 1'b0;
        @(negedge clk);
        check("rstmid_idle_busy", {31'd0, dif.busy}, 0);
        check("rstmid_quotient", dif.quotient, 0);
        check("rstmid_remainder", dif.remainder, 0);
        last_q = '0;
        last_r = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
                2: b = 32'($urandom_range(1, 20));
                3: b = -32'($urandom_range(1, 20));
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0)
                b2b(a, b, s, $urandom, 32'($urandom_range(0, 1000)), 1'b1);
            else
                run(a, b, s);
        end

        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
